// File: rtl/button_request_latch.sv
// Synchronises, debounces and latches raw elevator hall/car buttons into sticky
// request vectors. Optional macro REQ_CANCEL_EN: re-pressing a set car button cancels it.
module button_request_latch #(
    parameter int DEBOUNCE_CYCLES = 10,
    parameter int CNT_W           = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] rawFloorButton,
    input  logic [9:1]  rawInternalButton,
    input  logic [13:0] nextFloorButton,
    input  logic [9:1]  nextInternalButton,
    output logic [13:0] floorButton,
    output logic [9:1]  internalButton,
    output logic        newRequest,
    output logic [4:0]  pendingCount
);

    localparam int NUM_RAW = 23;
    localparam int NUM_LAT = 21;
    // Floor 1 has no down button and floor 7 has no up button.
    localparam logic [NUM_LAT-1:0] VALID_MASK = 21'h1F_EFFD;
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    logic [NUM_RAW-1:0] raw_all;
    logic [NUM_RAW-1:0] sync1_q, sync1_d;
    logic [NUM_RAW-1:0] sync2_q, sync2_d;
    logic [NUM_RAW-1:0] stable_q, stable_d;
    logic [CNT_W-1:0]   cnt_q [NUM_RAW];
    logic [CNT_W-1:0]   cnt_d [NUM_RAW];
    logic [NUM_LAT-1:0] stable_prev_q, stable_prev_d;
    logic [NUM_LAT-1:0] press_q, press_d;
    logic [NUM_LAT-1:0] latch_q, latch_d;
    logic [NUM_LAT-1:0] latch_prev_q, latch_prev_d;
    logic [NUM_LAT-1:0] next_all;
    logic [NUM_LAT-1:0] clear;
    logic               new_req_q, new_req_d;
    logic [4:0]         pend_q, pend_d;
    logic               unused_next;

    // Bits [13:0] hall, [20:14] car floors 1-7, [22:21] door open/close.
    assign raw_all     = {rawInternalButton, rawFloorButton};
    assign next_all    = {nextInternalButton[7:1], nextFloorButton};
    assign unused_next = ^nextInternalButton[9:8];

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        sync1_d  = raw_all;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < NUM_RAW; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        stable_prev_d = stable_q[NUM_LAT-1:0];
        press_d       = stable_q[NUM_LAT-1:0] & ~stable_prev_q;
    end

    always_comb begin
        clear = latch_q & ~next_all;
`ifdef REQ_CANCEL_EN
        // A press on an already-set car bit toggles it off, even against a coincident clear.
        latch_d = (press_q | (latch_q & ~clear)) & ~(press_q & latch_q & 21'h1F_C000);
`else
        latch_d = press_q | (latch_q & ~clear);
`endif
        latch_d      = latch_d & VALID_MASK;
        latch_prev_d = latch_q;
        new_req_d    = |(latch_q & ~latch_prev_q);
        pend_d       = '0;
        for (int i = 0; i < NUM_LAT; i++) begin
            pend_d = pend_d + {4'b0000, latch_d[i]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            press_q       <= '0;
            latch_q       <= '0;
            latch_prev_q  <= '0;
            new_req_q     <= 1'b0;
            pend_q        <= '0;
            // NOTE: the counter array is ordinary flops, not RAM, so it is reset like the rest.
            for (int i = 0; i < NUM_RAW; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            cnt_q         <= cnt_d;
            stable_prev_q <= stable_prev_d;
            press_q       <= press_d;
            latch_q       <= latch_d;
            latch_prev_q  <= latch_prev_d;
            new_req_q     <= new_req_d;
            pend_q        <= pend_d;
        end
    end

    assign floorButton    = latch_q[13:0];
    assign internalButton = {stable_q[22:21], latch_q[20:14]};
    assign newRequest     = new_req_q;
    assign pendingCount   = pend_q;

endmodule

// File: doc/button_request_latch.md
Name: button_request_latch

Overview:
- Upstream stage of the 2-way 7-floor elevator controller.
- Samples raw hall and car pushbuttons, synchronises and debounces them, and latches each press into a sticky request vector.
- That vector drives the controller's floorButton/internalButton inputs.
- A latched bit clears when the controller drops it from nextFloorButton/nextInternalButton, i.e. the request was served.

Parameters:
- DEBOUNCE_CYCLES, 10, consecutive cycles a synchronised input must differ from its stable value before the stable value updates (min 2).
- CNT_W, 4, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, all flops on rising edge
- reset  input  1  asynchronous active-low reset
- rawFloorButton  input  14  raw hall buttons; pair [2k+1:2k] = floor k+1, bit 2k up, bit 2k+1 down
- rawInternalButton  input  [9:1]  raw car buttons; [7:1] floors 1-7, [8] door-open, [9] door-close
- nextFloorButton  input  14  controller's returned hall vector (served bits cleared)
- nextInternalButton  input  [9:1]  controller's returned car vector
- floorButton  output  14  latched hall requests to controller
- internalButton  output  [9:1]  latched car requests [7:1], debounced level [9:8]
- newRequest  output  1  one-cycle pulse when any latched bit rises 0->1
- pendingCount  output  5  number of set bits in floorButton plus internalButton[7:1]

Behaviour:
- Reset (reset=0, asynchronous): all sync flops, stable values, counters, latches, newRequest and pendingCount = 0. After release, all activity restarts from zero.
- Sync: two-flop synchroniser per raw bit, 23 bits total.
- Debounce, per bit: counter clears whenever synced == stable. Otherwise it increments. When the counter == DEBOUNCE_CYCLES-1 and synced still differs, stable <= synced and the counter clears.
  - A change must persist DEBOUNCE_CYCLES consecutive cycles.
  - Any equal cycle restarts the count.
- Press event: stable rising edge (stable 0->1). Release is ignored, except for bits [9:8].
- Latency: raw high sampled at edge 0 -> latched bit set at edge DEBOUNCE_CYCLES+3 (13 at default).
- Latch, hall bits and car bits [7:1]:
  - clear_i = out_i & ~next_i (controller dropped the bit).
  - out_i <= press_i | (out_i & ~clear_i).
  - Simultaneous press and clear: bit stays 1.
  - Press on an already-set bit: no change, no newRequest.
- Invalid hall bits 1 (floor 1 down) and 12 (floor 7 up) are forced 0 regardless of input.
- Bits [9:8] are not latched: internalButton[9:8] = debounced stable level. nextInternalButton[9:8] is ignored. These bits are excluded from pendingCount and newRequest.
- newRequest: registered, high for exactly one cycle after any latched bit transitions 0->1. Multiple simultaneous sets give one pulse.
- pendingCount: registered popcount of latched bits (max 19), updated the same edge as the latches.

Optional Feature:
- Macro: REQ_CANCEL_EN.
- Defined: a press event on internalButton[k] (k=1..7) while that bit is already 1 clears it (toggle/cancel). Press-and-clear coinciding with cancel still clears. Hall bits are unaffected.
- Undefined: re-press of a set bit is ignored.

Test Plan:
- rawFloorButton=14'h0040 (floor 4 up) held 20 cycles, nextFloorButton=floorButton -> floorButton[6]=1 at edge 13; newRequest pulses once at edge 14; pendingCount=1.
- rawInternalButton[3] high 5 cycles then low -> internalButton stays 0, pendingCount=0, no newRequest.
- floorButton[6]=1, drive nextFloorButton[6]=0 for one cycle -> floorButton[6]=0 next edge, pendingCount 1->0. Repeat with a debounced press landing on the same edge -> bit stays 1.
- rawFloorButton=14'h1002 (invalid bits 12,1) held 30 cycles -> floorButton=0, no newRequest.
- rawFloorButton bits 2,3 plus rawInternalButton[9:1]=9'b00_100_0001 pressed together -> one newRequest pulse, pendingCount=4; internalButton[9:8] not latched.
- Drive reset=0 at debounce count 6, release -> all outputs 0; input must then persist a full 13 edges to latch.
- With REQ_CANCEL_EN: internalButton[5]=1, re-press -> cleared, pendingCount decrements. Without the macro -> remains 1.
